tb_status_responder: RTL and testbench

- Memory-mapped test-status slave on the core data bus inside the verification wrapper; the other end of the pass/fail/exit signals consumed by the top-level bench.
- Responds to core loads/stores at a fixed base and turns firmware stores into tests_passed_o, tests_failed_o and exit_valid_o/exit_value_o, plus a stdout byte stream.
- Exposes read-only cycle and retired-store counters so firmware can timestamp itself.

---
 rtl/tb_status_pkg.sv | 23 ++
 rtl/tb_status_regfile.sv | 65 ++++++
 rtl/tb_status_responder.sv | 177 +++++++++++++++++
 tb/tb_tb_status_responder.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_status_pkg.sv
// Shared definitions for the test-status responder: register offsets, FSM states, watchdog code.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tb_status_pkg;

   // Byte offsets inside the 32-byte register window
   localparam logic [4:0] OFF_PRINT  = 5'h00;
   localparam logic [4:0] OFF_PASS   = 5'h04;
   localparam logic [4:0] OFF_FAIL   = 5'h08;
   localparam logic [4:0] OFF_EXIT   = 5'h0C;
   localparam logic [4:0] OFF_CYCLE  = 5'h10;
   localparam logic [4:0] OFF_STORES = 5'h14;

   // Exit code reported when the watchdog ends the run
   localparam logic [31:0] WATCHDOG_CODE = 32'hDEAD_0001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RESP = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/tb_status_regfile.sv
// Address decode, exit-code byte merge and read mux for the test-status window.
// Latency: purely combinational; the parent registers every result.
// Backpressure: none; only evaluated for a granted access (valid).
module tb_status_regfile
   import tb_status_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
   input  logic        valid,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] exit_cur,
   input  logic [31:0] cycle_cnt,
   input  logic [31:0] store_cnt,
   output logic        print_hit,
   output logic        pass_hit,
   output logic        fail_hit,
   output logic        exit_hit,
   output logic [31:0] exit_next,
   output logic [31:0] rdata
);

   logic       hit;
   logic       wr;
   logic       rd;
   logic [4:0] off;
   logic [1:0] unused_addr;

   // Window is 32 bytes: bits [4:2] select the word, [1:0] are ignored
   assign hit         = addr[31:5] == BASE_ADDR[31:5];
   assign off         = {addr[4:2], 2'b00};
   assign unused_addr = addr[1:0];
   assign wr          = valid && we && hit;
   assign rd          = valid && !we && hit;

   assign print_hit = wr && (off == OFF_PRINT) && be[0];
   assign pass_hit  = wr && (off == OFF_PASS) && (|be) && (wdata != 32'd0);
   assign fail_hit  = wr && (off == OFF_FAIL) && (|be) && (wdata != 32'd0);
   assign exit_hit  = wr && (off == OFF_EXIT);

   // Exit code update: only enabled byte lanes take the store data
   always_comb begin
      exit_next = exit_cur;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            exit_next[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   // Read mux: counters only; write-only and unused words read as zero
   always_comb begin
      rdata = 32'd0;
      if (rd) begin
         case (off)
            OFF_CYCLE:  rdata = cycle_cnt;
            OFF_STORES: rdata = store_cnt;
            default:    rdata = 32'd0;
         endcase
      end
   end

endmodule

// File: rtl/tb_status_responder.sv
// Memory-mapped test-status slave: stdout bytes, pass/fail/exit pulses, cycle/store counters.
// Latency: grant is combinational; response and all pulses follow exactly one cycle after grant.
// Backpressure: one outstanding access; grant is withheld in the response cycle. Optional watchdog: TB_STATUS_WATCHDOG_EN.
module tb_status_responder
   import tb_status_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
   parameter int unsigned CNT_WIDTH  = 32,
   parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        data_req_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_addr_i,
   input  logic [31:0] data_wdata_i,
   output logic [31:0] data_rdata_o,
   output logic        print_valid_o,
   output logic [7:0]  print_char_o,
   output logic        tests_passed_o,
   output logic        tests_failed_o,
   output logic        exit_valid_o,
   output logic [31:0] exit_value_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic                 fin_q, fin_d;
   logic                 gnt;
   logic                 finished;
   logic                 status_en;
   logic                 status_hit;
   logic                 wd_fire;
   logic [CNT_WIDTH-1:0] cycle_q;
   logic [CNT_WIDTH-1:0] stores_q;

   logic                 print_hit, pass_hit, fail_hit, exit_hit;
   logic [31:0]          exit_next;
   logic [31:0]          rf_rdata;

   logic                 rvalid_q;
   logic [31:0]          rdata_q;
   logic                 print_vld_q;
   logic [7:0]           print_char_q;
   logic                 pass_q;
   logic                 fail_q;
   logic                 exit_vld_q;
   logic [31:0]          exit_value_q;

   assign gnt = data_req_i && (state_q != RESP);

   // A response cycle already committed to DONE counts as finished, so a
   // status store cannot be followed by a second status event.
   assign finished   = (state_q == DONE) || ((state_q == RESP) && fin_q);
   assign status_en  = !finished;
   assign status_hit = status_en && (pass_hit || fail_hit || exit_hit);

`ifdef TB_STATUS_WATCHDOG_EN
   assign wd_fire = (32'(cycle_q) == MAX_CYCLES) && !finished;
`else
   logic unused_max_cycles;
   assign wd_fire           = 1'b0;
   assign unused_max_cycles = ^MAX_CYCLES;
`endif

   tb_status_regfile #(
      .BASE_ADDR (BASE_ADDR)
   ) u_regfile (
      .valid     (gnt),
      .we        (data_we_i),
      .be        (data_be_i),
      .addr      (data_addr_i),
      .wdata     (data_wdata_i),
      .exit_cur  (exit_value_q),
      .cycle_cnt (32'(cycle_q)),
      .store_cnt (32'(stores_q)),
      .print_hit (print_hit),
      .pass_hit  (pass_hit),
      .fail_hit  (fail_hit),
      .exit_hit  (exit_hit),
      .exit_next (exit_next),
      .rdata     (rf_rdata)
   );

   // Next state: a grant always passes through RESP; fin_d remembers where RESP returns to
   always_comb begin
      state_d = state_q;
      fin_d   = fin_q;
      case (state_q)
         IDLE, DONE: begin
            if (gnt) begin
               state_d = RESP;
               fin_d   = finished || status_hit || wd_fire;
            end else if (wd_fire) begin
               state_d = DONE;
            end
         end
         RESP: begin
            state_d = (fin_q || wd_fire) ? DONE : IDLE;
            fin_d   = 1'b0;
         end
         default: begin
            state_d = IDLE;
            fin_d   = 1'b0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         fin_q   <= fin_d;
      end
   end

   // Free-running cycle counter and granted-store counter, both wrapping
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_q  <= '0;
         stores_q <= '0;
      end else begin
         cycle_q <= cycle_q + CNT_ONE;
         if (gnt && data_we_i) begin
            stores_q <= stores_q + CNT_ONE;
         end
      end
   end

   // Response and event outputs, all registered from the grant cycle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q     <= 1'b0;
         rdata_q      <= 32'd0;
         print_vld_q  <= 1'b0;
         print_char_q <= 8'd0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         exit_vld_q   <= 1'b0;
         exit_value_q <= 32'd0;
      end else begin
         rvalid_q    <= gnt;
         rdata_q     <= rf_rdata;
         print_vld_q <= print_hit;
         if (print_hit) begin
            print_char_q <= data_wdata_i[7:0];
         end
         pass_q     <= pass_hit && status_en;
         fail_q     <= fail_hit && status_en;
         exit_vld_q <= (exit_hit && status_en) || wd_fire;
         // An EXIT store in the same cycle as watchdog expiry keeps its own code
         if (exit_hit && status_en) begin
            exit_value_q <= exit_next;
         end else if (wd_fire) begin
            exit_value_q <= WATCHDOG_CODE;
         end
      end
   end

   assign data_gnt_o     = gnt;
   assign data_rvalid_o  = rvalid_q;
   assign data_rdata_o   = rdata_q;
   assign print_valid_o  = print_vld_q;
   assign print_char_o   = print_char_q;
   assign tests_passed_o = pass_q;
   assign tests_failed_o = fail_q;
   assign exit_valid_o   = exit_vld_q;
   assign exit_value_o   = exit_value_q;

endmodule

// File: tb/tb_tb_status_responder.sv
// Bench for tb_status_responder: directed accesses, cycle-level reference model, literal pins.
// Latency: model predicts gnt combinationally and all responses one cycle after grant.
// Backpressure: bench issues one access at a time except in the held-request sequence.
module tb_tb_status_responder;

   localparam logic [31:0] BASE   = 32'h2000_0000;
   localparam logic [31:0] WD_MAX = 32'd100;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        req    = 1'b0;
   logic        we     = 1'b0;
   logic [3:0]  be     = 4'd0;
   logic [31:0] addr   = 32'd0;
   logic [31:0] wdata  = 32'd0;

   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        pv;
   logic [7:0]  pc;
   logic        pass;
   logic        fail;
   logic        ev;
   logic [31:0] evalue;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tb_status_responder #(
      .BASE_ADDR  (BASE),
      .CNT_WIDTH  (32),
      .MAX_CYCLES (WD_MAX)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .data_req_i     (req),
      .data_gnt_o     (gnt),
      .data_rvalid_o  (rvalid),
      .data_we_i      (we),
      .data_be_i      (be),
      .data_addr_i    (addr),
      .data_wdata_i   (wdata),
      .data_rdata_o   (rdata),
      .print_valid_o  (pv),
      .print_char_o   (pc),
      .tests_passed_o (pass),
      .tests_failed_o (fail),
      .exit_valid_o   (ev),
      .exit_value_o   (evalue)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: what the outputs must show in the cycle after each edge
   logic        m_pending, m_done;
   logic [31:0] m_cycle, m_stores, m_exit;
   logic        e_rvalid, e_pv, e_pass, e_fail, e_ev;
   logic [31:0] e_rdata;
   logic [7:0]  e_pc;

   always @(posedge clk or negedge rst_n) begin : model
      logic        g, wd, ex_store, nd;
      logic [2:0]  w;
      logic [31:0] nexit;
      if (!rst_n) begin
         m_pending <= 1'b0;
         m_done    <= 1'b0;
         m_cycle   <= 32'd0;
         m_stores  <= 32'd0;
         m_exit    <= 32'd0;
         e_rvalid  <= 1'b0;
         e_rdata   <= 32'd0;
         e_pv      <= 1'b0;
         e_pc      <= 8'd0;
         e_pass    <= 1'b0;
         e_fail    <= 1'b0;
         e_ev      <= 1'b0;
      end else begin
         g        = req && !m_pending;
         w        = addr[4:2];
         nexit    = m_exit;
         ex_store = 1'b0;
         nd       = m_done;
`ifdef TB_STATUS_WATCHDOG_EN
         wd = (m_cycle == WD_MAX) && !m_done;
`else
         wd = 1'b0;
`endif
         e_rvalid <= g;
         e_rdata  <= 32'd0;
         e_pv     <= 1'b0;
         e_pass   <= 1'b0;
         e_fail   <= 1'b0;
         if (g && (addr[31:5] == BASE[31:5])) begin
            if (we) begin
               if (w == 3'd0 && be[0]) begin
                  e_pv <= 1'b1;
                  e_pc <= wdata[7:0];
               end
               if (!m_done && (w == 3'd1 || w == 3'd2) && be != 4'd0 && wdata != 32'd0) begin
                  if (w == 3'd1) e_pass <= 1'b1;
                  else           e_fail <= 1'b1;
                  nd = 1'b1;
               end
               if (!m_done && w == 3'd3) begin
                  for (int b = 0; b < 4; b++)
                     if (be[b]) nexit[8*b +: 8] = wdata[8*b +: 8];
                  ex_store = 1'b1;
                  nd       = 1'b1;
               end
            end else if (w == 3'd4) begin
               e_rdata <= m_cycle;
            end else if (w == 3'd5) begin
               e_rdata <= m_stores;
            end
         end
         if (wd) begin
            nd = 1'b1;
            if (!ex_store) nexit = 32'hDEAD_0001;
         end
         e_ev      <= ex_store || wd;
         m_exit    <= nexit;
         m_done    <= nd;
         m_pending <= g;
         m_cycle   <= m_cycle + 32'd1;
         if (g && we) m_stores <= m_stores + 32'd1;
      end
   end

   // Compare every output against the model on every falling edge
   always @(negedge clk) begin
      check("gnt", gnt, req && !m_pending);
      check("rvalid", rvalid, e_rvalid);
      check("rdata", rdata, e_rdata);
      check("print_valid", pv, e_pv);
      if (e_pv) check("print_char", pc, e_pc);
      check("tests_passed", pass, e_pass);
      check("tests_failed", fail, e_fail);
      check("exit_valid", ev, e_ev);
      check("exit_value", evalue, m_exit);
   end

   // Captured results of the last single access
   logic        c_gnt, c_rv, c_pv, c_pass, c_fail, c_ev;
   logic [31:0] c_rd, c_evalue;
   logic [7:0]  c_pc;

   // One access: request for one cycle, capture grant, then capture the response cycle
   task automatic xfer(input logic w, input logic [4:0] off, input logic [3:0] b, input logic [31:0] d);
      req   = 1'b1;
      we    = w;
      addr  = BASE | {27'd0, off};
      be    = b;
      wdata = d;
      @(negedge clk);
      c_gnt = gnt;
      @(posedge clk);
      #1;
      req   = 1'b0;
      we    = 1'b0;
      be    = 4'd0;
      wdata = 32'd0;
      @(negedge clk);
      c_rv     = rvalid;
      c_rd     = rdata;
      c_pv     = pv;
      c_pc     = pc;
      c_pass   = pass;
      c_fail   = fail;
      c_ev     = ev;
      c_evalue = evalue;
      @(posedge clk);
      #1;
   endtask

   // Reset for one cycle; returns at release, which is cycle 0 of the counter
   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("reset_rvalid", rvalid, 1'b0);
      check("reset_exit_value", evalue, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int n;
      int at;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_rvalid", rvalid, 1'b0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_print_valid", pv, 1'b0);
      check("rst_print_char", pc, 8'd0);
      check("rst_pass", pass, 1'b0);
      check("rst_fail", fail, 1'b0);
      check("rst_exit_valid", ev, 1'b0);
      check("rst_exit_value", evalue, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // CYCLE load granted in cycle 20 after release
      repeat (20) @(posedge clk);
      #1;
      xfer(1'b0, 5'h10, 4'hF, 32'd0);
      check("cycle_gnt", c_gnt, 1'b1);
      check("cycle_rvalid", c_rv, 1'b1);
      check("cycle_rdata", c_rd, 32'd20);

      // Unmapped word reads zero
      xfer(1'b0, 5'h1C, 4'hF, 32'd0);
      check("unmapped_rvalid", c_rv, 1'b1);
      check("unmapped_rdata", c_rd, 32'd0);

      // PRINT 'A'
      xfer(1'b1, 5'h00, 4'b0001, 32'h0000_0041);
      check("print_gnt", c_gnt, 1'b1);
      check("print_rvalid", c_rv, 1'b1);
      check("print_strobe", c_pv, 1'b1);
      check("print_char_a", c_pc, 8'h41);

      // PASS pulse, one cycle only
      xfer(1'b1, 5'h04, 4'hF, 32'd1);
      check("pass_rvalid", c_rv, 1'b1);
      check("pass_pulse", c_pass, 1'b1);
      @(negedge clk);
      check("pass_one_cycle", pass, 1'b0);
      @(posedge clk);
      #1;

      // FAIL after DONE is ignored but still answered
      xfer(1'b1, 5'h08, 4'hF, 32'd1);
      check("fail_done_rvalid", c_rv, 1'b1);
      check("fail_done_ignored", c_fail, 1'b0);

      // Held request: grant alternates, three stores counted
      do_reset();
      req   = 1'b1;
      we    = 1'b1;
      addr  = BASE | 32'h18;
      be    = 4'hF;
      wdata = 32'hFFFF_FFFF;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("b2b_gnt", gnt, (i % 2 == 0) ? 1'b1 : 1'b0);
         @(posedge clk);
         #1;
      end
      req = 1'b0;
      we  = 1'b0;
      xfer(1'b0, 5'h14, 4'hF, 32'd0);
      check("stores_rdata", c_rd, 32'd3);

      // EXIT with two low byte lanes
      do_reset();
      xfer(1'b1, 5'h0C, 4'b0011, 32'h1234_5678);
      check("exit_pulse", c_ev, 1'b1);
      check("exit_merge", c_evalue, 32'h0000_5678);
      n = 0;
      repeat (5) begin
         @(negedge clk);
         if (ev) n++;
         @(posedge clk);
         #1;
      end
      check("exit_once", n, 0);
      check("exit_held", evalue, 32'h0000_5678);

      // Reset during a granted PASS store drops the response
      do_reset();
      req   = 1'b1;
      we    = 1'b1;
      addr  = BASE | 32'h04;
      be    = 4'hF;
      wdata = 32'd1;
      #2 rst_n = 1'b0;
      @(posedge clk);
      #1;
      req   = 1'b0;
      we    = 1'b0;
      wdata = 32'd0;
      @(negedge clk);
      check("midrst_rvalid", rvalid, 1'b0);
      check("midrst_pass", pass, 1'b0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("midrst_rvalid_after", rvalid, 1'b0);
      check("midrst_pass_after", pass, 1'b0);
      @(posedge clk);
      #1;
      xfer(1'b1, 5'h04, 4'hF, 32'd7);
      check("pass_after_reset", c_pass, 1'b1);

`ifdef TB_STATUS_WATCHDOG_EN
      // Watchdog: counter equals 100 in cycle 100, pulse is registered into cycle 101
      do_reset();
      n  = 0;
      at = -1;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         if (ev) begin
            n++;
            at = k;
         end
         @(posedge clk);
         #1;
      end
      check("wd_pulses", n, 1);
      check("wd_cycle", at, 101);
      check("wd_code", evalue, 32'hDEAD_0001);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1);
   end

endmodule
